// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: architectural PC, next-PC select and BOOT/RUN/HALT control.
// Optional retire counter port enabled by defining FETCH_RETIRE_COUNT_EN.
module fetch_pc_unit #(
    parameter int unsigned    N         = 32,
    parameter int unsigned    MEM_DEPTH = 16,
    parameter logic [N-1:0]   RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic         jump,
    input  logic [N-1:0] target,
    input  logic [31:0]  instruction_in,
    output logic [N-1:0] program_counter,
    output logic [N-1:0] pc_plus4,
`ifdef FETCH_RETIRE_COUNT_EN
    output logic [N-1:0] retire_count,
`endif
    output logic         fetch_valid,
    output logic         halted,
    output logic         fault
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int unsigned  LAST_I    = MEM_DEPTH * 4 - 4;
    localparam logic [N-1:0] PC_LAST   = N'(LAST_I);
    localparam logic [31:0]  SELF_LOOP = 32'h0000_006f;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         fault_q, fault_d;
    logic         flt_entry;
    logic [N-1:0] pc_inc;
    logic         redirect;
    logic         tgt_bad;
    logic         seq_bad;

    assign pc_inc   = pc_q + N'(4);
    assign redirect = branch_taken | jump;
    assign tgt_bad  = (target[1:0] != 2'b00) || (target > PC_LAST);
    assign seq_bad  = pc_inc > PC_LAST;

    // State, PC and fault-flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and next-PC selection; redirect beats the self-loop halt
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        flt_entry = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!stall) begin
                    if (redirect) begin
                        if (tgt_bad) begin
                            state_d   = HALT;
                            fault_d   = 1'b1;
                            flt_entry = 1'b1;
                        end else begin
                            pc_d = target;
                        end
                    end else if (instruction_in == SELF_LOOP) begin
                        state_d = HALT;
                    end else if (seq_bad) begin
                        state_d   = HALT;
                        fault_d   = 1'b1;
                        flt_entry = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        program_counter = pc_q;
        pc_plus4        = pc_inc;
        fetch_valid     = (state_q == RUN) && !stall;
        halted          = (state_q == HALT);
        fault           = fault_q;
    end

`ifdef FETCH_RETIRE_COUNT_EN
    logic [N-1:0] retire_q;

    // Count accepted fetches; a faulting fetch does not retire
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
        end else if ((state_q == RUN) && !stall && !flt_entry) begin
            retire_q <= retire_q + N'(1);
        end
    end

    assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] SLP = 32'h0000_006f;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic [31:0] target;
    logic [31:0] instruction_in;
    logic [31:0] program_counter;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        fault;
`ifdef FETCH_RETIRE_COUNT_EN
    logic [31:0] retire_count;
`endif

    fetch_pc_unit #(
        .N         (32),
        .MEM_DEPTH (16),
        .RESET_PC  (32'd0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .jump            (jump),
        .target          (target),
        .instruction_in  (instruction_in),
        .program_counter (program_counter),
        .pc_plus4        (pc_plus4),
`ifdef FETCH_RETIRE_COUNT_EN
        .retire_count    (retire_count),
`endif
        .fetch_valid     (fetch_valid),
        .halted          (halted),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        fv;
        logic        h;
        logic        f;
        int          rc;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   sid    = 0;

    // Monitor: compare the outputs of the current cycle with the queued entry
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [66:0] act;
            logic [66:0] req;
            e   = q.pop_front();
            act = {program_counter, pc_plus4, fetch_valid, halted, fault};
            req = {e.pc, e.pc + 32'd4, e.fv, e.h, e.f};
            n_vec++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL vec%0d: got pc=%0d pc4=%0d fv=%b h=%b f=%b, want pc=%0d pc4=%0d fv=%b h=%b f=%b",
                         e.id, program_counter, pc_plus4, fetch_valid,
                         halted, fault, e.pc, e.pc + 32'd4, e.fv, e.h, e.f);
            end
`ifdef FETCH_RETIRE_COUNT_EN
            if (e.rc >= 0) begin
                n_vec++;
                if (retire_count !== 32'(e.rc)) begin
                    n_fail++;
                    $display("FAIL rc%0d: got retire_count=%0d want %0d",
                             e.id, retire_count, e.rc);
                end
            end
`endif
        end
    end

    task automatic step(
        input logic        rst,
        input logic        stl,
        input logic        br,
        input logic        jmp,
        input logic [31:0] tgt,
        input logic [31:0] ins,
        input logic [31:0] epc,
        input logic        efv,
        input logic        eh,
        input logic        ef,
        input int          erc
    );
        exp_t e;
        reset          = rst;
        stall          = stl;
        branch_taken   = br;
        jump           = jmp;
        target         = tgt;
        instruction_in = ins;
        sid++;
        e.id = sid;
        e.pc = epc;
        e.fv = efv;
        e.h  = eh;
        e.f  = ef;
        e.rc = erc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        jump           = 1'b0;
        target         = '0;
        instruction_in = NOP;
        @(posedge clk);
        #1;
        //    rst  stl  br   jmp  tgt  instr  pc  fv   h    f   rc
        // Boot and sequential run, stall at PC 8
        step(0, 0, 0, 0,  0, NOP,  0, 0, 0, 0, 0);
        step(0, 0, 0, 0,  0, NOP,  0, 1, 0, 0, 0);
        step(0, 0, 0, 0,  0, NOP,  4, 1, 0, 0, 1);
        step(0, 1, 0, 0,  0, NOP,  8, 0, 0, 0, 2);
        step(0, 1, 0, 0,  0, SLP,  8, 0, 0, 0, 2);
        step(0, 1, 0, 1, 40, NOP,  8, 0, 0, 0, 2);
        step(0, 0, 0, 0,  0, NOP,  8, 1, 0, 0, 2);
        step(0, 0, 0, 0,  0, NOP, 12, 1, 0, 0, 3);
        // Branch to 48, back to 16, jump to 48, misaligned jump
        step(0, 0, 1, 0, 48, NOP, 16, 1, 0, 0, 4);
        step(0, 0, 1, 0, 16, NOP, 48, 1, 0, 0, 5);
        step(0, 0, 0, 1, 48, NOP, 16, 1, 0, 0, 6);
        step(0, 0, 0, 1, 18, NOP, 48, 1, 0, 0, 7);
        step(0, 0, 0, 0,  0, NOP, 48, 0, 1, 1, 7);
        step(0, 0, 1, 0,  0, SLP, 48, 0, 1, 1, 7);
        step(1, 0, 0, 0,  0, NOP, 48, 0, 1, 1, 7);
        // Both redirects with self-loop encoding; run off the end at 60
        step(0, 0, 0, 0,  0, NOP,  0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 52, SLP,  0, 1, 0, 0, 0);
        step(0, 0, 0, 0,  0, NOP, 52, 1, 0, 0, 1);
        step(0, 0, 0, 0,  0, NOP, 56, 1, 0, 0, 2);
        step(0, 0, 0, 0,  0, NOP, 60, 1, 0, 0, 3);
        step(1, 0, 0, 0,  0, NOP, 60, 0, 1, 1, 3);
        // Stall ignored in BOOT; aligned but out-of-range jump target
        step(0, 1, 0, 0,  0, NOP,  0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 64, NOP,  0, 1, 0, 0, 0);
        step(1, 0, 0, 0,  0, NOP,  0, 0, 1, 1, 0);
        // Self-loop halt at 56, held ten cycles, then reset
        step(0, 0, 0, 0,  0, NOP,  0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 56, NOP,  0, 1, 0, 0, 0);
        step(0, 0, 0, 0,  0, SLP, 56, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(i == 9, i[0], i[1], i[2], 32'(i * 4), NOP,
                 56, 0, 1, 0, 2);
        end
        step(0, 0, 0, 0,  0, NOP,  0, 0, 0, 0, 0);
        step(0, 0, 0, 0,  0, NOP,  0, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
